// File: rtl/ifu_fetch.sv
// ifu_fetch: program counter owner and single-outstanding instruction fetch.
// Issues one imem read per instruction, holds the returned word for the
// decoder behind a valid/ready handshake, and honours redirects and halt.
// Every output is a flop or a direct copy of one, so no combinational path
// runs from imem_rsp_* / inst_ready / redirect / halt to an output.
module ifu_fetch #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted,
  output logic              misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  // drop: the outstanding response belongs to a stale PC and must be discarded
  logic              drop;
  // halt_pending: halt seen while a read is in flight; stop once it returns
  logic              halt_pending;

  // Redirect targets are word aligned by clearing the low bits; a non-zero
  // low pair is reported through the sticky misalign flag.
  logic [ADDR_W-1:0] redirect_tgt;
  logic              redirect_mis;

  assign redirect_tgt  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_mis  = |redirect_pc[1:0];
  assign imem_req_addr = pc;

  // Fetch FSM: state, PC, held instruction and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      inst           <= '0;
      inst_pc        <= RESET_PC;
      inst_valid     <= 1'b0;
      imem_req_valid <= 1'b0;
      halted         <= 1'b0;
      misalign       <= 1'b0;
      drop           <= 1'b0;
      halt_pending   <= 1'b0;
    end else begin
      case (state)
        // One settling cycle out of reset; redirects are not taken here.
        S_IDLE: begin
          if (halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state          <= S_REQ;
            imem_req_valid <= 1'b1;
          end
        end

        // Request presented at pc. A redirect in the same cycle as
        // acceptance still lets the old address go out, so mark it stale.
        S_REQ: begin
          if (halt) begin
            state          <= S_HALT;
            imem_req_valid <= 1'b0;
            halted         <= 1'b1;
          end else begin
            if (redirect_valid) begin
              pc <= redirect_tgt;
              if (redirect_mis) misalign <= 1'b1;
            end
            if (imem_req_ready) begin
              state          <= S_WAIT;
              imem_req_valid <= 1'b0;
              drop           <= redirect_valid;
            end
          end
        end

        // Waiting for the single-cycle response pulse.
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (halt || halt_pending) begin
              state        <= S_HALT;
              halted       <= 1'b1;
              halt_pending <= 1'b0;
              drop         <= 1'b0;
            end else if (drop || redirect_valid) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
              drop           <= 1'b0;
              if (redirect_valid) begin
                pc <= redirect_tgt;
                if (redirect_mis) misalign <= 1'b1;
              end
            end else begin
              state      <= S_HOLD;
              inst       <= imem_rsp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
            end
          end else if (halt) begin
            halt_pending <= 1'b1;
          end else if (redirect_valid && !halt_pending) begin
            drop <= 1'b1;
            pc   <= redirect_tgt;
            if (redirect_mis) misalign <= 1'b1;
          end
        end

        // Word offered to the decoder; halt, then redirect, beat the +4.
        S_HOLD: begin
          if (halt) begin
            state      <= S_HALT;
            inst_valid <= 1'b0;
            halted     <= 1'b1;
          end else if (redirect_valid) begin
            state          <= S_REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            pc             <= redirect_tgt;
            if (redirect_mis) misalign <= 1'b1;
          end else if (inst_ready) begin
            state          <= S_REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
            pc             <= pc + ADDR_W'(4);
          end
        end

        // Absorbing until reset.
        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state          <= S_IDLE;
          inst_valid     <= 1'b0;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level fetch model.
module tb_ifu_fetch;
  localparam int          ADDR_W   = 64;
  localparam int          INST_W   = 32;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [INST_W-1:0] imem_rsp_data = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              halted;
  logic              misalign;

  ifu_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction memory contents: one fixed word, everything else a hash.
  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0010_0093;
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // ---------------- memory responder + stimulus helpers ----------------
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [63:0] mem_addr = '0;
  int          lat_mode = 1;  // 0: random 1..3 cycles, else fixed latency

  // Advance one clock; returns 1 time unit after the rising edge with the
  // pulse inputs cleared and the memory response for this cycle driven.
  task automatic cyc();
    bit          acc;
    logic [63:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst_n) mem_pend = 1'b0;
    else if (acc) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
    end
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(mem_addr);
        mem_pend       = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_pc: next address to fetch; m_out: a read is in flight (m_stale if its
  // data must be thrown away); m_hold: a word is owed to the decoder.
  logic [63:0] m_pc, m_out_addr, m_hold_addr;
  bit          m_idle, m_halted, m_out, m_stale, m_hold, m_hpend, m_mis;

  initial begin
    bit exp_req, acc, rsp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pc = RESET_PC; m_out_addr = '0; m_hold_addr = '0;
        m_idle = 1; m_halted = 0; m_out = 0; m_stale = 0;
        m_hold = 0; m_hpend = 0; m_mis = 0;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_pc", inst_pc, RESET_PC);
        chk("rst_inst", inst, 0);
      end else begin
        exp_req = !m_idle && !m_halted && !m_out && !m_hold;
        chk("mon_req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("mon_req_addr", imem_req_addr, m_pc);
        chk("mon_inst_valid", inst_valid, m_hold);
        if (m_hold) begin
          chk("mon_inst", inst, memf(m_hold_addr));
          chk("mon_inst_pc", inst_pc, m_hold_addr);
        end
        chk("mon_halted", halted, m_halted);
        chk("mon_misalign", misalign, m_mis);

        // what the coming rising edge does
        acc = exp_req && imem_req_ready;
        rsp = imem_rsp_valid && m_out;
        if (m_idle) begin
          m_idle = 0;
          if (halt) m_halted = 1;
        end else if (!m_halted) begin
          if (halt) begin
            if (m_out && !rsp) m_hpend = 1;
            else begin m_halted = 1; m_out = 0; m_hold = 0; end
          end else if (m_hpend) begin
            if (rsp) begin m_halted = 1; m_out = 0; m_hpend = 0; end
          end else if (redirect_valid) begin
            m_pc = redirect_pc & ~64'h3;
            if (redirect_pc[1:0] != 2'b00) m_mis = 1;
            m_hold = 0;
            if (m_out) begin
              if (rsp) m_out = 0;
              else m_stale = 1;
            end
            if (acc) begin m_out = 1; m_stale = 1; end
          end else if (rsp) begin
            m_out = 0;
            if (!m_stale) begin m_hold = 1; m_hold_addr = m_out_addr; end
          end else if (acc) begin
            m_out = 1; m_stale = 0; m_out_addr = m_pc;
          end else if (m_hold && inst_ready) begin
            m_hold = 0;
            m_pc   = m_hold_addr + 64'd4;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          got, seen, bad;
    logic [63:0] rp;

    // reset release, ready memory, 1-cycle latency
    lat_mode = 1;
    repeat (2) cyc();
    chk("t1_reset_req_valid", imem_req_valid, 0);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    cyc();
    chk("t1_req_valid", imem_req_valid, 1);
    chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
    cyc();
    chk("t1_wait_no_req", imem_req_valid, 0);
    cyc();
    chk("t1_inst_valid", inst_valid, 1);
    chk("t1_inst", inst, 32'h0010_0093);
    chk("t1_inst_pc", inst_pc, 64'h8000_0000);

    // decoder stalls for 5 cycles
    bad = 0;
    repeat (5) begin
      cyc();
      if (!inst_valid || imem_req_valid || inst != 32'h0010_0093 || inst_pc != 64'h8000_0000) bad = 1;
    end
    chk("t2_stall_stable", bad, 0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("t2_next_req_valid", imem_req_valid, 1);
    chk("t2_next_req_addr", imem_req_addr, 64'h8000_0004);

    // redirect during WAIT discards the in-flight response
    lat_mode = 3;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    got = 0; seen = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      if (inst_valid) seen = 1;
      if (imem_req_valid) got = 1;
    end
    chk("t3_req_returns", got, 1);
    chk("t3_no_inst", seen, 0);
    chk("t3_req_addr", imem_req_addr, 64'h8000_0100);

    // misaligned redirect in HOLD beats inst_ready
    lat_mode = 1;
    cyc();
    cyc();
    chk("t4_hold_valid", inst_valid, 1);
    chk("t4_hold_pc", inst_pc, 64'h8000_0100);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0202;
    cyc();
    inst_ready = 1'b0;
    chk("t4_dropped", inst_valid, 0);
    chk("t4_misalign", misalign, 1);
    chk("t4_req_valid", imem_req_valid, 1);
    chk("t4_req_addr", imem_req_addr, 64'h8000_0200);

    // halt during WAIT, response 3 cycles after acceptance
    lat_mode = 3;
    cyc();
    halt = 1'b1;
    got = 0; seen = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cyc();
      if (inst_valid) seen = 1;
      if (halted) got = 1;
    end
    chk("t5_halted", got, 1);
    chk("t5_no_inst", seen, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i % 4 == 0) begin redirect_valid = 1'b1; redirect_pc = 64'h8000_0400; end
      if (imem_req_valid || inst_valid || !halted) bad = 1;
    end
    chk("t5_quiet", bad, 0);

    // reset in the middle of WAIT
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0013;
    cyc();
    chk("t6_misalign_set", misalign, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_req_valid", imem_req_valid, 0);
    chk("t6_async_misalign", misalign, 0);
    chk("t6_async_addr", imem_req_addr, RESET_PC);
    chk("t6_async_inst_pc", inst_pc, RESET_PC);
    cyc();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;  // late response lands in IDLE
    imem_rsp_data  = 32'hDEAD_BEEF;
    cyc();
    chk("t6_req_valid", imem_req_valid, 1);
    chk("t6_req_addr", imem_req_addr, RESET_PC);
    chk("t6_no_inst", inst_valid, 0);

    // halt and redirect together: halt wins
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_1000;
    cyc();
    chk("t7_halted", halted, 1);
    chk("t7_no_req", imem_req_valid, 0);
    bad = 0;
    repeat (5) begin
      cyc();
      if (imem_req_valid) bad = 1;
    end
    chk("t7_quiet", bad, 0);

    // randomized traffic, model checks every cycle
    lat_mode = 0;
    for (int ep = 0; ep < 6; ep++) begin
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      inst_ready = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
        cyc();
        imem_req_ready = ($urandom_range(0, 9) < 7);
        inst_ready     = ($urandom_range(0, 9) < 6);
        if (c >= 1 && $urandom_range(0, 19) == 0) begin
          rp = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 64'd4;
          if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
          if ($urandom_range(0, 4) == 0) rp[1:0] = 2'($urandom_range(1, 3));
          redirect_valid = 1'b1;
          redirect_pc    = rp;
        end
        if (ep != 5 && $urandom_range(0, 999) < 1) halt = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1);
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the NPC core: owns the program counter, issues one instruction-memory read per instruction, and presents the returned 32-bit instruction word plus its PC to the decoder stage through a valid/ready handshake. It sits directly upstream of the decoder. It accepts PC redirects from the execute stage (jumps/branches) and a halt request (ebreak). One instruction is in flight at a time; there is no prefetch.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded at reset
- ADDR_W, 64, PC / memory address width
- INST_W, 32, instruction width; must equal the decoder's instruction width
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  ADDR_W  read address (= pc)
- imem_rsp_valid  input  1  read data valid, single-cycle pulse, never before acceptance
- imem_rsp_data  input  INST_W  read data
- inst_valid  output  1  instruction held for decoder
- inst_ready  input  1  decoder consumes instruction
- inst  output  INST_W  instruction word to decoder
- inst_pc  output  ADDR_W  PC of `inst`
- redirect_valid  input  1  replace next PC (single-cycle pulse)
- redirect_pc  input  ADDR_W  redirect target
- halt  input  1  stop fetching (ebreak)
- halted  output  1  fetch stopped permanently until reset
- misalign  output  1  sticky: a redirect target had pc[1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. Reset state IDLE; IDLE -> REQ unconditionally next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready -> WAIT. Address stable while stalled.
- WAIT: on imem_rsp_valid, capture data into inst register, inst_pc <= pc, -> HOLD; if a drop flag is set, discard data, clear drop, -> REQ.
- HOLD: inst_valid=1. On inst_ready: pc <= pc + 4 (mod 2^ADDR_W, wraps silently), -> REQ.
- Redirect: pc <= redirect_pc in any state except HALT/IDLE-after-reset-only. REQ: address changes next cycle (request not accepted same cycle it is redirected is still accepted with old address only if ready was high that cycle; in that case drop is set). WAIT: set drop flag, stay WAIT. HOLD: inst_valid cleared, held word discarded, -> REQ; redirect overrides the +4 even if inst_ready is high the same cycle.
- redirect_pc[1:0] != 0: misalign <= 1 (sticky), pc <= redirect_pc with bits[1:0] forced to 0.
- Halt: wins over redirect. From IDLE/REQ/HOLD -> HALT next cycle (held word dropped, even if inst_ready same cycle). From WAIT: set halt_pending, stay until response, discard it, -> HALT. HALT is absorbing: all request/valid outputs 0, halted=1.
- Drop flag and halt_pending cleared on reset only via state exit as described.

## Timing
- Reset values (asynchronous): state IDLE, pc=RESET_PC, inst=0, inst_pc=RESET_PC, inst_valid=0, imem_req_valid=0, halted=0, misalign=0, drop=0, halt_pending=0.
- All outputs are registered or decoded from state only; no combinational path from imem_rsp_* or inst_ready to any output.
- Minimum latency: request accepted at cycle N, response at N+1, inst_valid at N+2. Best-case throughput one instruction per 3 cycles (REQ, WAIT, HOLD with immediate ready).
- Reset assertion mid-transaction aborts everything; a late imem_rsp_valid arriving in IDLE/REQ is ignored.

## Test plan
- Reset release, memory ready always, 1-cycle response with 0x00100093 at 0x80000000 -> req addr 0x80000000 in cycle 1, inst_valid with inst=0x00100093, inst_pc=0x80000000 two cycles after acceptance; next request addr 0x80000004.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, no new request issued; pc advances by exactly 4 after ready.
- Redirect to 0x80000100 during WAIT -> pending response discarded (never reaches inst_valid), next request addr 0x80000100.
- Redirect to 0x80000202 in HOLD with inst_ready=1 same cycle -> held word dropped, misalign=1, next request addr 0x80000200.
- halt during WAIT with response 3 cycles later -> response discarded, halted=1, imem_req_valid stays 0 for 20 cycles; halt+redirect same cycle -> halted, no redirect request.
- Drive rst_n low mid-WAIT -> outputs return to reset values immediately; fetch restarts at RESET_PC.
